// File: rtl/rand_pkg.sv
// rand_pkg: shared types for the random-number prefetcher.
// Holds the FSM state encoding and the generator register offsets.
package rand_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STRM,
        S_READ,
        S_NEXT,
        S_GAP
    } state_t;

    localparam logic [31:0] OFF_NUM    = 32'h0;
    localparam logic [31:0] OFF_STREAM = 32'h4;

endpackage

// File: rtl/rand_fifo.sv
// rand_fifo: first-word-fall-through word FIFO for prefetched numbers.
// Ports: push/data in, pop/head out, flush clears, count/valid report fill.
module rand_fifo
    import rand_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [31:0] data,
    output logic [31:0] head,
    output logic [6:0]  count,
    output logic        valid
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          do_push;
    logic          do_pop;

    assign valid   = (count != 7'd0);
    assign head    = mem[rp];
    // A flush wins over anything else in the same cycle.
    assign do_pop  = pop & valid & ~flush;
    assign do_push = push & ~flush;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + PTR_ONE;
            if (do_pop)  rp <= rp + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + 7'd1;
                2'b01:   count <= count - 7'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wp] <= data;
    end

endmodule

// File: rtl/rand_prefetch.sv
// rand_prefetch: Wishbone master that keeps a FIFO of random numbers full.
// Ports: wishbone master (cyc/stb/we/sel/adr/dat, ack/dat_i), stream_i
// selects the generator stream, rd_i pops dout_o, err_o flags a bus timeout.
module rand_prefetch
    import rand_pkg::*;
#(
    parameter logic [31:0] RAND_ADDR = 32'hFDFF4000,
    parameter int          DEPTH     = 8,
    parameter int          TMO       = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [3:0]  sel_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    input  logic        ack_i,
    input  logic [31:0] dat_i,
    input  logic [9:0]  stream_i,
    input  logic        rd_i,
    output logic [31:0] dout_o,
    output logic        valid_o,
    output logic [6:0]  count_o,
    output logic        err_o
);

    localparam int TW = (TMO > 1) ? $clog2(TMO + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);
    localparam logic [6:0]    DEPTH_C  = 7'(DEPTH);

    state_t        state;
    state_t        state_nx;
    state_t        pick;
    logic [TW-1:0] wcnt;
    logic [9:0]    cur_stream;
    logic          strm_ok;
    logic          pend_next;
    logic          bus;
    logic          ack;
    logic          tmo;
    logic          done;
    logic          need_strm;
    logic          room;

    assign bus  = (state == S_STRM) || (state == S_READ) || (state == S_NEXT);
    assign ack  = ack_i & bus;
    assign tmo  = bus & ~ack_i & (wcnt == TMO_LAST);
    assign done = ack | tmo;

    assign need_strm = ~strm_ok | (stream_i != cur_stream);
    assign room      = (count_o < DEPTH_C);

    // An acked READ owes the generator a NEXT before anything else.
    always_comb begin
        pick = S_IDLE;
        if (pend_next)      pick = S_NEXT;
        else if (need_strm) pick = S_STRM;
        else if (room)      pick = S_READ;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE, S_GAP: state_nx = pick;
            S_STRM, S_READ, S_NEXT: begin
                if (done) state_nx = S_GAP;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        cyc_o = 1'b0;
        stb_o = 1'b0;
        we_o  = 1'b0;
        adr_o = '0;
        dat_o = '0;
        unique case (state)
            S_STRM: begin
                cyc_o = 1'b1;
                stb_o = 1'b1;
                we_o  = 1'b1;
                adr_o = RAND_ADDR + OFF_STREAM;
                dat_o = {22'd0, cur_stream};
            end
            S_READ: begin
                cyc_o = 1'b1;
                stb_o = 1'b1;
                adr_o = RAND_ADDR + OFF_NUM;
            end
            S_NEXT: begin
                cyc_o = 1'b1;
                stb_o = 1'b1;
                we_o  = 1'b1;
                adr_o = RAND_ADDR + OFF_NUM;
            end
            default: ;
        endcase
    end

    assign sel_o = stb_o ? 4'hF : 4'h0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            wcnt       <= '0;
            cur_stream <= '0;
            strm_ok    <= 1'b0;
            pend_next  <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            state <= state_nx;
            wcnt  <= (bus && !done) ? wcnt + TW'(1) : '0;
            if (tmo) err_o <= 1'b1;
            // Stream is captured on STRM entry so dat_o stays stable;
            // it only counts as written once the responder acks.
            if (state != S_STRM && state_nx == S_STRM) begin
                cur_stream <= stream_i;
                strm_ok    <= 1'b0;
            end else if (state == S_STRM && ack) begin
                strm_ok <= 1'b1;
            end
            if (state == S_READ && ack) pend_next <= 1'b1;
            else if (state == S_NEXT)   pend_next <= 1'b0;
        end
    end

    rand_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .push (state == S_READ && ack),
        .pop  (rd_i),
        .flush(state == S_STRM && ack),
        .data (dat_i),
        .head (dout_o),
        .count(count_o),
        .valid(valid_o)
    );

endmodule

// File: tb/tb_rand_prefetch.sv
// tb_rand_prefetch: directed bench for rand_prefetch.
// A wishbone responder model acks after a set delay and logs transfers.
module tb_rand_prefetch;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [3:0]  sel_o;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic        ack_i;
    logic [31:0] dat_i;
    logic [9:0]  stream_i;
    logic        rd_i;
    logic [31:0] dout_o;
    logic        valid_o;
    logic [6:0]  count_o;
    logic        err_o;

    int total = 0;
    int bad = 0;

    bit          ack_en = 1'b1;
    int          ack_dly = 2;
    int          rcnt = 0;
    int          nread = 0;
    logic [64:0] log_q [512];
    int          log_n = 0;
    int          gap_bad = 0;
    int          sel_bad = 0;
    bit          prev_ack = 1'b0;

    localparam logic [64:0] E_READ = {1'b0, 32'hFDFF4000, 32'h0};
    localparam logic [64:0] E_NEXT = {1'b1, 32'hFDFF4000, 32'h0};

    rand_prefetch dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .cyc_o   (cyc_o),
        .stb_o   (stb_o),
        .we_o    (we_o),
        .sel_o   (sel_o),
        .adr_o   (adr_o),
        .dat_o   (dat_o),
        .ack_i   (ack_i),
        .dat_i   (dat_i),
        .stream_i(stream_i),
        .rd_i    (rd_i),
        .dout_o  (dout_o),
        .valid_o (valid_o),
        .count_o (count_o),
        .err_o   (err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (cyc_o && stb_o) begin
            rcnt++;
            if (ack_en && rcnt > ack_dly && !ack_i) begin
                ack_i = 1'b1;
                dat_i = we_o ? 32'h0 : 32'h12345678 + 32'(nread);
                if (!we_o) nread++;
                if (log_n < 512) log_q[log_n] = {we_o, adr_o, dat_o};
                log_n++;
            end
        end else begin
            rcnt  = 0;
            ack_i = 1'b0;
        end
    end

    always @(posedge clk_i) begin
        if (prev_ack && cyc_o) gap_bad++;
        prev_ack = ack_i && cyc_o;
        if (sel_o !== (stb_o ? 4'hF : 4'h0)) sel_bad++;
        if (cyc_o !== stb_o) sel_bad++;
    end

    task automatic pop1();
        rd_i = 1'b1;
        @(negedge clk_i); #1;
        rd_i = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) begin
            @(negedge clk_i); #1;
        end
    endtask

    task automatic test_reset();
        rst_i    = 1'b1;
        stream_i = 10'd5;
        rd_i     = 1'b0;
        ack_i    = 1'b0;
        dat_i    = 32'h0;
        settle(3);
        total++;
        if ({cyc_o, stb_o, we_o, sel_o, valid_o, err_o} !== 9'd0) begin
            bad++;
            $display("FAIL reset_ctl: got %b want 0",
                     {cyc_o, stb_o, we_o, sel_o, valid_o, err_o});
        end
        total++;
        if (adr_o !== 32'h0 || dat_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_bus: adr %h dat %h want 0", adr_o, dat_o);
        end
        total++;
        if (count_o !== 7'd0) begin
            bad++;
            $display("FAIL reset_count: got %0d want 0", count_o);
        end
    endtask

    task automatic test_first_strm();
        bit ok = 1'b0;
        rst_i = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk_i); #1;
            if (log_n >= 2) ok = 1'b1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL first_wait: got %0d xfers want 2", log_n);
        end
        total++;
        if (log_q[0] !== {1'b1, 32'hFDFF4004, 32'h5}) begin
            bad++;
            $display("FAIL first_strm: got %h want %h", log_q[0],
                     {1'b1, 32'hFDFF4004, 32'h5});
        end
        total++;
        if (log_q[1] !== E_READ) begin
            bad++;
            $display("FAIL first_read: got %h want %h", log_q[1], E_READ);
        end
    endtask

    task automatic test_fill();
        bit ok = 1'b0;
        int busy = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk_i); #1;
            if (count_o == 7'd8) ok = 1'b1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL fill_wait: got %0d want 8", count_o);
        end
        settle(10);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i); #1;
            if (cyc_o) busy++;
        end
        total++;
        if (busy != 0) begin
            bad++;
            $display("FAIL fill_idle: got %0d busy cycles want 0", busy);
        end
        total++;
        if (count_o !== 7'd8 || dout_o !== 32'h12345678) begin
            bad++;
            $display("FAIL fill_head: count %0d dout %h want 8 12345678",
                     count_o, dout_o);
        end
        total++;
        if (log_n != 17) begin
            bad++;
            $display("FAIL fill_xfers: got %0d want 17", log_n);
        end
        for (int k = 0; k < 8; k++) begin
            total++;
            if (log_q[1 + 2 * k] !== E_READ || log_q[2 + 2 * k] !== E_NEXT) begin
                bad++;
                $display("FAIL fill_order%0d: got %h %h want %h %h", k,
                         log_q[1 + 2 * k], log_q[2 + 2 * k], E_READ, E_NEXT);
            end
        end
        total++;
        if (err_o !== 1'b0) begin
            bad++;
            $display("FAIL fill_err: got %b want 0", err_o);
        end
    endtask

    task automatic test_full_pop();
        int n0 = log_n;
        pop1();
        total++;
        if (count_o !== 7'd7) begin
            bad++;
            $display("FAIL fullpop_cnt: got %0d want 7", count_o);
        end
        settle(40);
        total++;
        if (log_n != n0 + 2 || log_q[n0] !== E_READ || log_q[n0 + 1] !== E_NEXT) begin
            bad++;
            $display("FAIL fullpop_xfers: got %0d want %0d", log_n - n0, 2);
        end
        total++;
        if (count_o !== 7'd8 || dout_o !== 32'h12345679) begin
            bad++;
            $display("FAIL fullpop_head: count %0d dout %h want 8 12345679",
                     count_o, dout_o);
        end
    endtask

    task automatic test_pop_on_ack();
        bit ok = 1'b0;
        pop1();
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk_i); #1;
            if (ack_i && stb_o && !we_o) ok = 1'b1;
        end
        total++;
        if (!ok || count_o !== 7'd7) begin
            bad++;
            $display("FAIL popack_setup: ok %0d count %0d want 1 7", ok, count_o);
        end
        pop1();
        total++;
        if (count_o !== 7'd7 || dout_o !== 32'h1234567B) begin
            bad++;
            $display("FAIL popack_cnt: count %0d dout %h want 7 1234567b",
                     count_o, dout_o);
        end
        settle(30);
        total++;
        if (count_o !== 7'd8 || dout_o !== 32'h1234567B) begin
            bad++;
            $display("FAIL popack_refill: count %0d dout %h want 8 1234567b",
                     count_o, dout_o);
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (dout_o !== 32'h1234567B + 32'(i)) begin
                bad++;
                $display("FAIL drain%0d: got %h want %h", i, dout_o,
                         32'h1234567B + 32'(i));
            end
            pop1();
        end
        settle(120);
    endtask

    task automatic test_timeout();
        bit ok = 1'b0;
        int n = 1;
        ack_en = 1'b0;
        pop1();
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk_i); #1;
            if (cyc_o) ok = 1'b1;
        end
        for (int i = 0; i < 400 && ok; i++) begin
            @(negedge clk_i); #1;
            if (cyc_o) n++;
            else ok = 1'b0;
        end
        total++;
        if (n != 255) begin
            bad++;
            $display("FAIL tmo_len: got %0d cycles want 255", n);
        end
        total++;
        if (err_o !== 1'b1 || count_o !== 7'd7) begin
            bad++;
            $display("FAIL tmo_state: err %b count %0d want 1 7", err_o, count_o);
        end
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk_i); #1;
            if (cyc_o) ok = 1'b1;
        end
        total++;
        if (!ok || adr_o !== 32'hFDFF4000 || we_o !== 1'b0) begin
            bad++;
            $display("FAIL tmo_retry: cyc %b adr %h we %b want 1 fdff4000 0",
                     cyc_o, adr_o, we_o);
        end
        ack_en = 1'b1;
        settle(40);
        total++;
        if (count_o !== 7'd8 || err_o !== 1'b1) begin
            bad++;
            $display("FAIL tmo_recover: count %0d err %b want 8 1", count_o, err_o);
        end
    endtask

    task automatic test_stream_change();
        bit ok = 1'b0;
        int nflush = 0;
        rd_i = 1'b1;
        settle(4);
        rd_i = 1'b0;
        stream_i = 10'd9;
        total++;
        if (count_o == 7'd0) begin
            bad++;
            $display("FAIL strm_pre: got %0d want nonzero", count_o);
        end
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk_i); #1;
            if (ack_i && we_o && adr_o == 32'hFDFF4004) ok = 1'b1;
        end
        total++;
        if (!ok || dat_o !== 32'h9) begin
            bad++;
            $display("FAIL strm_write: ok %0d dat %h want 1 9", ok, dat_o);
        end
        total++;
        if (log_n < 2 || log_q[log_n - 2] !== E_NEXT) begin
            bad++;
            $display("FAIL strm_prev: got %h want %h", log_q[log_n - 2], E_NEXT);
        end
        nflush = nread;
        pop1();
        total++;
        if (count_o !== 7'd0 || valid_o !== 1'b0) begin
            bad++;
            $display("FAIL strm_flush: count %0d valid %b want 0 0",
                     count_o, valid_o);
        end
        settle(100);
        total++;
        if (count_o !== 7'd8 || dout_o !== 32'h12345678 + 32'(nflush)) begin
            bad++;
            $display("FAIL strm_refill: count %0d dout %h want 8 %h", count_o,
                     dout_o, 32'h12345678 + 32'(nflush));
        end
    endtask

    task automatic test_reset_mid();
        bit ok = 1'b0;
        pop1();
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk_i); #1;
            if (cyc_o && !we_o) ok = 1'b1;
        end
        rst_i = 1'b1;
        #1;
        total++;
        if (!ok || cyc_o !== 1'b0 || stb_o !== 1'b0 || adr_o !== 32'h0) begin
            bad++;
            $display("FAIL rstmid_bus: ok %0d cyc %b stb %b adr %h want 1 0 0 0",
                     ok, cyc_o, stb_o, adr_o);
        end
        total++;
        if (count_o !== 7'd0 || valid_o !== 1'b0 || err_o !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_state: count %0d valid %b err %b want 0 0 0",
                     count_o, valid_o, err_o);
        end
        @(negedge clk_i); #1;
        log_n = 0;
        rst_i = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk_i); #1;
            if (log_n >= 1) ok = 1'b1;
        end
        total++;
        if (!ok || log_q[0] !== {1'b1, 32'hFDFF4004, 32'h9}) begin
            bad++;
            $display("FAIL rstmid_strm: got %h want %h", log_q[0],
                     {1'b1, 32'hFDFF4004, 32'h9});
        end
    endtask

    task automatic test_protocol();
        total++;
        if (gap_bad != 0) begin
            bad++;
            $display("FAIL gap: got %0d violations want 0", gap_bad);
        end
        total++;
        if (sel_bad != 0) begin
            bad++;
            $display("FAIL sel: got %0d violations want 0", sel_bad);
        end
    endtask

    initial begin
        test_reset();
        test_first_strm();
        test_fill();
        test_full_pop();
        test_pop_on_ack();
        test_timeout();
        test_stream_change();
        test_reset_mid();
        test_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
